uart_tx: RTL and testbench

- 8-bit asynchronous serial transmitter, LSB first, 8N1 framing by default; drives the SoC's uart_txd pin.
- Complements the existing receive path on uart_rxd.
- CPU bridge pushes bytes into a small FIFO.
- FIFO decouples the CPU bridge from the bit-rate timing of the serial line.

---
 rtl/uart_tx.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter, LSB first, 8N1 framing, fed by a small FIFO.
// Optional macro UART_TX_PARITY_EN inserts a parity bit (even, or odd when
// PARITY_ODD=1) between the last data bit and the stop bit.
module uart_tx #(
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk_in,
  input  logic       sys_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_ovf,
  output logic       uart_txd
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [FCNT_W-1:0] FIFO_CAP  = FCNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic       PAR_ODD  = 1'(PARITY_ODD);
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Elaboration-time parameter range checks
  if (BAUD_DIV < 1 || BAUD_DIV > 65535) begin : g_bad_baud
    $error("uart_tx: BAUD_DIV out of range 1..65535");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              ovf_q, ovf_d, busy_q, busy_d, txd_q, txd_d;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic              push, pop, bit_end;
  logic [7:0]        head;

  assign push    = tx_we & ~full_q;
  assign bit_end = (baud_q == BAUD_LAST);
  assign head    = fifo_q[rd_ptr_q];

  // Frame sequencer: next state, baud counter, shift register and pop request
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          idx_d   = '0;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = (^head) ^ PAR_ODD;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!empty_q) begin
            // Chain straight into the next start bit, no idle gap
            pop     = 1'b1;
            state_d = S_START;
            idx_d   = '0;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = (^head) ^ PAR_ODD;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so it changes on the same edge
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping, status flags and sticky overflow
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FIFO_CAP);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | (tx_we & full_q);
    busy_d  = (state_d != S_IDLE) | ~empty_d;
  end

  // FIFO storage; stale entries are harmless since pointers reset
  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr_q] <= tx_data;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      txd_q    <= 1'b1;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      txd_q    <= txd_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_full  = full_q;
  assign tx_empty = empty_q;
  assign tx_busy  = busy_q;
  assign tx_ovf   = ovf_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, FIFO, overflow and reset.
// DUT a runs at BAUD_DIV=4, DUT b at BAUD_DIV=1.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, we_a, full_a, empty_a, busy_a, ovf_a, txd_a;
  logic [7:0] data_a;
  logic       rst_b, we_b, full_b, empty_b, busy_b, ovf_b, txd_b;
  logic [7:0] data_b;

  uart_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_a (
    .clk_in(clk), .sys_rst(rst_a), .tx_data(data_a), .tx_we(we_a),
    .tx_full(full_a), .tx_empty(empty_a), .tx_busy(busy_a), .tx_ovf(ovf_a),
    .uart_txd(txd_a));

  uart_tx #(.BAUD_DIV(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_b (
    .clk_in(clk), .sys_rst(rst_b), .tx_data(data_b), .tx_we(we_b),
    .tx_full(full_b), .tx_empty(empty_b), .tx_busy(busy_b), .tx_ovf(ovf_b),
    .uart_txd(txd_b));

  int checks = 0;
  int failures = 0;

  // Bench receiver state, one slot per DUT
  bit         rx_act [2];
  int         rx_pos [2];
  int         rx_err [2];
  logic [7:0] rx_byte [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  // Mid-bit sampling receiver; abandons a frame when the DUT drops busy
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin : rx_lane
      logic line, bsy;
      int   bd, bi;
      line = (s == 0) ? txd_a : txd_b;
      bsy  = (s == 0) ? busy_a : busy_b;
      bd   = (s == 0) ? 4 : 1;
      if (rx_act[s] && bsy !== 1'b1) rx_act[s] = 1'b0;
      if (!rx_act[s] && line === 1'b0) begin
        rx_act[s] = 1'b1;
        rx_pos[s] = 0;
      end
      if (rx_act[s]) begin
        if (rx_pos[s] % bd == bd / 2) begin
          bi = rx_pos[s] / bd;
          if (bi == 0) begin
            if (line !== 1'b0) rx_err[s]++;
          end else if (bi <= 8) begin
            rx_byte[s][bi-1] = line;
`ifdef UART_TX_PARITY_EN
          end else if (bi == 9) begin
            if (line !== (^rx_byte[s])) rx_err[s]++;
`endif
          end else begin
            if (line !== 1'b1) rx_err[s]++;
            if (s == 0) q0.push_back(rx_byte[s]);
            else        q1.push_back(rx_byte[s]);
            rx_act[s] = 1'b0;
          end
        end
        rx_pos[s]++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic wait_low(input int sel, input int budget, input string tag);
    int n = 0;
    while (line_of(sel) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(line_of(sel)), 32'd0);
  endtask

  task automatic wait_idle(input int sel, input int budget, input string tag);
    int n = 0;
    while (busy_of(sel) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy_of(sel)), 32'd0);
  endtask

  // Samples nbits bit slots of bd cycles each; bad counts unstable slots
  task automatic capture(input int sel, input int nbits, input int bd,
                         output logic [15:0] v, output int bad);
    v   = '0;
    bad = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < bd; k++) begin
        if (k == 0) v[b] = line_of(sel);
        else if (line_of(sel) !== v[b]) bad++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [15:0] v1, v2;
    int          bad1, bad2, hold_hi, sent, guard;
    logic [7:0]  expq [$];

    rst_a = 1'b1; we_a = 1'b0; data_a = 8'h00;
    rst_b = 1'b1; we_b = 1'b0; data_b = 8'h00;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    chk("rst_txd",   32'(txd_a),   32'd1);
    chk("rst_full",  32'(full_a),  32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_ovf",   32'(ovf_a),   32'd0);
    chk("rst_txd_b", 32'(txd_b),   32'd1);

    // Single byte 0x55 at BAUD_DIV=4
    q0.delete();
    data_a = 8'h55; we_a = 1'b1;
    @(negedge clk);
    we_a = 1'b0;
    chk("t1_txd_e0",   32'(txd_a),   32'd1);
    chk("t1_busy_e0",  32'(busy_a),  32'd1);
    chk("t1_empty_e0", 32'(empty_a), 32'd0);
    @(negedge clk);
    wait_low(0, 2, "t1_start");
    capture(0, 10, 4, v1, bad1);
    chk("t1_frame",  32'(v1), 32'h2AA);
    chk("t1_stable", 32'(bad1), 32'd0);
    chk("t1_busy_end",  32'(busy_a),  32'd0);
    chk("t1_empty_end", 32'(empty_a), 32'd1);
    chk("t1_txd_end",   32'(txd_a),   32'd1);

    // Back-to-back 0xA3, 0x0F: second start follows first stop directly
    q0.delete();
    data_a = 8'hA3; we_a = 1'b1;
    @(negedge clk);
    data_a = 8'h0F;
    @(negedge clk);
    we_a = 1'b0;
    wait_low(0, 2, "t2_start");
    capture(0, 10, 4, v1, bad1);
    capture(0, 10, 4, v2, bad2);
    chk("t2_frame1", 32'(v1), 32'h346);
    chk("t2_frame2", 32'(v2), 32'h21E);
    chk("t2_stable", 32'(bad1 + bad2), 32'd0);
    chk("t2_busy_end", 32'(busy_a), 32'd0);

    // Overflow: six writes, fifth fills the FIFO, sixth dropped
    q0.delete();
    for (int i = 1; i <= 6; i++) begin
      data_a = 8'(i); we_a = 1'b1;
      @(negedge clk);
    end
    we_a = 1'b0;
    chk("t3_full", 32'(full_a), 32'd1);
    chk("t3_ovf",  32'(ovf_a),  32'd1);
    wait_idle(0, 400, "t3_idle");
    chk("t3_nframes", 32'(q0.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t3_byte", (i < q0.size()) ? 32'(q0[i]) : 32'hxxxx_xxxx, 32'(i + 1));
    chk("t3_ovf_sticky", 32'(ovf_a), 32'd1);
    chk("t3_rx_err", 32'(rx_err[0]), 32'd0);

    // Reset during data bit 3 of 0xF0 with two bytes queued
    q0.delete();
    data_a = 8'hF0; we_a = 1'b1;
    @(negedge clk);
    data_a = 8'h11;
    @(negedge clk);
    data_a = 8'h22;
    @(negedge clk);
    we_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_txd_pre", 32'(txd_a), 32'd0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("t4_txd",   32'(txd_a),   32'd1);
    chk("t4_empty", 32'(empty_a), 32'd1);
    chk("t4_busy",  32'(busy_a),  32'd0);
    chk("t4_ovf",   32'(ovf_a),   32'd0);
    chk("t4_full",  32'(full_a),  32'd0);
    hold_hi = 1;
    repeat (100) begin
      @(negedge clk);
      if (txd_a !== 1'b1) hold_hi = 0;
    end
    chk("t4_stays_idle", 32'(hold_hi), 32'd1);
    chk("t4_no_frames",  32'(q0.size()), 32'd0);

    // 0x07 at BAUD_DIV=1 (parity slot only with the macro)
    data_b = 8'h07; we_b = 1'b1;
    @(negedge clk);
    we_b = 1'b0;
    @(negedge clk);
    wait_low(1, 2, "t5_start");
    capture(1, NB, 1, v1, bad1);
`ifdef UART_TX_PARITY_EN
    chk("t5_frame", 32'(v1), 32'h60E);
`else
    chk("t5_frame", 32'(v1), 32'h20E);
`endif
    chk("t5_busy_end", 32'(busy_b), 32'd0);

    // Stress: 20 random bytes pushed whenever not full
    q1.delete();
    sent = 0; guard = 0;
    while (sent < 20 && guard < 2000) begin
      if (full_b === 1'b0) begin
        data_b = 8'($urandom_range(0, 255));
        we_b   = 1'b1;
        expq.push_back(data_b);
        sent++;
      end else begin
        we_b = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    we_b = 1'b0;
    chk("t6_sent", 32'(sent), 32'd20);
    wait_idle(1, 600, "t6_idle");
    chk("t6_nbytes", 32'(q1.size()), 32'd20);
    for (int i = 0; i < expq.size(); i++)
      chk("t6_byte", (i < q1.size()) ? 32'(q1[i]) : 32'hxxxx_xxxx, 32'(expq[i]));
    chk("t6_ovf",    32'(ovf_b),     32'd0);
    chk("t6_rx_err", 32'(rx_err[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
